// File: rtl/qed_pkg.sv
// Shared constants, state encoding and instruction helpers for the
// SQED duplication front end.
package qed_pkg;

   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic {ORIG = 1'b0, DUP = 1'b1} state_e;

   // Which register fields an opcode actually uses.
   typedef struct packed {
      logic rd;
      logic rs1;
      logic rs2;
   } reg_use_t;

   function automatic reg_use_t reg_use(input logic [6:0] opc);
      reg_use_t u;
      u = '0;
      case (opc)
         OPC_OP:     u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b1};
         OPC_OP_IMM: u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b0};
         OPC_LOAD:   u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b0};
         OPC_STORE:  u = '{rd: 1'b0, rs1: 1'b1, rs2: 1'b1};
         default:    u = '0;
      endcase
      return u;
   endfunction

   // Supported opcode, and every used register lies in the original half.
   function automatic logic is_legal(input logic [31:0] instr, input int unsigned reg_split);
      reg_use_t u;
      logic     opc_ok;
      u = reg_use(instr[6:0]);
      opc_ok = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM) ||
               (instr[6:0] == OPC_LOAD) || (instr[6:0] == OPC_STORE);
      return opc_ok &&
             (!u.rd  || (32'(instr[11:7])  < reg_split)) &&
             (!u.rs1 || (32'(instr[19:15]) < reg_split)) &&
             (!u.rs2 || (32'(instr[24:20]) < reg_split));
   endfunction

   // Move every used nonzero register into the duplicate half; x0 stays x0.
   function automatic logic [31:0] remap(input logic [31:0] instr, input int unsigned reg_split);
      reg_use_t    u;
      logic [4:0]  off;
      logic [31:0] r;
      u   = reg_use(instr[6:0]);
      off = 5'(reg_split);
      r   = instr;
      if (u.rd  && (instr[11:7]  != 5'd0)) r[11:7]  = instr[11:7]  + off;
      if (u.rs1 && (instr[19:15] != 5'd0)) r[19:15] = instr[19:15] + off;
      if (u.rs2 && (instr[24:20] != 5'd0)) r[24:20] = instr[24:20] + off;
      return r;
   endfunction

endpackage

// File: rtl/qed_fifo.sv
// Synchronous FIFO holding the originals awaiting duplicate replay.
// Full/empty come from the occupancy count; pointers wrap modulo DEPTH.
module qed_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign do_push   = push && (count_q != FULL);
   assign do_pop    = pop && (count_q != '0);
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         count_d  = count_q + CW'(1);
      end else if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         count_d  = count_q - CW'(1);
      end
   end

   // Pointer and count registers; reset empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/qed_dup_queue.sv
// SQED duplication front end: issues originals while recording them, then
// on request replays them with registers moved into the duplicate half.
// Handshake: an original is taken on a rising edge when instr_valid and
// in_ready are both high; a held-off instruction must be re-offered.
module qed_dup_queue
   import qed_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter int unsigned REG_SPLIT = 16,
   localparam int         CW        = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   instruction,
   input  logic          instr_valid,
   input  logic          qed_exec_dup,
   input  logic          stall,
   output logic          in_ready,
   output logic [31:0]   qed_ifu_instruction,
   output logic          qed_vld_out,
   output logic          qed_ready,
   output logic [CW-1:0] queue_count,
   output logic          illegal_seen,
   output logic          state_dbg
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_e        state_q, state_d;
   logic [31:0]   instr_q, instr_d;
   logic          vld_q, vld_d;
   logic          illegal_q, illegal_d;
   logic          push, pop, accept, legal;
   logic [31:0]   head;
   logic [CW-1:0] count;

   qed_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (instruction),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   assign in_ready            = (state_q == ORIG) && !stall && (count != FULL);
   assign accept              = instr_valid && in_ready;
   assign legal               = is_legal(instruction, REG_SPLIT);
   assign qed_ifu_instruction = instr_q;
   assign qed_vld_out         = vld_q;
   assign illegal_seen        = illegal_q;
   assign queue_count         = count;
   assign qed_ready           = (state_q == ORIG) && (count == '0);
   assign state_dbg           = state_q;

   // Mode sequencing, queue control and next output values; stall freezes all.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      vld_d     = vld_q;
      illegal_d = illegal_q;
      push      = 1'b0;
      pop       = 1'b0;
      if (!stall) begin
         instr_d = NOP_INSTR;
         vld_d   = 1'b0;
         case (state_q)
            ORIG: begin
               if (accept) begin
                  if (legal) begin
                     push    = 1'b1;
                     instr_d = instruction;
                     vld_d   = 1'b1;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
               // A same-cycle push lands in the queue before the switch.
               if (qed_exec_dup && ((count != '0) || push)) state_d = DUP;
            end
            DUP: begin
               pop = (count != '0);
               if (pop) begin
                  instr_d = remap(head, REG_SPLIT);
                  vld_d   = 1'b1;
               end
               if (count <= CW'(1)) state_d = ORIG;
            end
            default: state_d = ORIG;
         endcase
      end
   end

   // State and registered outputs toward IF/ID.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ORIG;
         instr_q   <= NOP_INSTR;
         vld_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         vld_q     <= vld_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_qed_dup_queue.sv
// Directed bench for qed_dup_queue: driver tasks issue originals and
// duplicate requests, a monitor compares every valid output against an
// expected queue, and direct checks cover flags and counters.
module tb_qed_dup_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        qed_exec_dup;
   logic        stall;
   logic        in_ready;
   logic [31:0] qed_ifu_instruction;
   logic        qed_vld_out;
   logic        qed_ready;
   logic [4:0]  queue_count;
   logic        illegal_seen;
   logic        state_dbg;

   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic        edge_stall, edge_reset;
   logic [31:0] prev_instr;
   logic        prev_vld;

   qed_dup_queue #(.DEPTH(16), .REG_SPLIT(16)) dut (
      .clk                 (clk),
      .reset               (reset),
      .instruction         (instruction),
      .instr_valid         (instr_valid),
      .qed_exec_dup        (qed_exec_dup),
      .stall               (stall),
      .in_ready            (in_ready),
      .qed_ifu_instruction (qed_ifu_instruction),
      .qed_vld_out         (qed_vld_out),
      .qed_ready           (qed_ready),
      .queue_count         (queue_count),
      .illegal_seen        (illegal_seen),
      .state_dbg           (state_dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle; inputs return to idle after the edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic d, input logic s);
      instr_valid  = v;
      instruction  = ins;
      qed_exec_dup = d;
      stall        = s;
      @(posedge clk);
      #1;
      instr_valid  = 1'b0;
      instruction  = 32'h0;
      qed_exec_dup = 1'b0;
      stall        = 1'b0;
   endtask

   // Issue a legal original and expect it on the output stream.
   task automatic send_orig(input logic [31:0] ins);
      exp_q.push_back(ins);
      step(1'b1, ins, 1'b0, 1'b0);
   endtask

   // Fill all 16 entries, try a 17th, then replay with optional stalls.
   task automatic fill_and_drain(input bit with_stall);
      int cycles;
      for (int i = 0; i < 16; i++) send_orig(32'h0000_0093 | (32'(i) << 20));
      check("full_count", 32'(queue_count), 32'd16);
      check("full_in_ready", 32'(in_ready), 32'd0);
      step(1'b1, 32'h0000_0093 | (32'd16 << 20), 1'b0, 1'b0);
      check("full_reject_count", 32'(queue_count), 32'd16);
      check("full_reject_vld", 32'(qed_vld_out), 32'd0);
      for (int i = 0; i < 16; i++) exp_q.push_back(32'h0000_0893 | (32'(i) << 20));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("dup_state", 32'(state_dbg), 32'd1);
      check("dup_gap_vld", 32'(qed_vld_out), 32'd0);
      cycles = 0;
      while (queue_count != 5'd0 && cycles < 40) begin
         step(1'b0, 32'h0, 1'b0, with_stall && (cycles == 4 || cycles == 9));
         cycles++;
      end
      check("drain_cycles", 32'(cycles), with_stall ? 32'd18 : 32'd16);
      check("drain_ready", 32'(qed_ready), 32'd1);
   endtask

   // Capture what the DUT saw at the active edge.
   always @(posedge clk) begin
      edge_stall = stall;
      edge_reset = reset;
   end

   // Monitor: each unstalled valid output must match the next expectation.
   always @(negedge clk) begin
      if (edge_reset === 1'b0 && reset === 1'b0) begin
         if (edge_stall) begin
            check("hold_instr", qed_ifu_instruction, prev_instr);
            check("hold_vld", 32'(qed_vld_out), 32'(prev_vld));
         end else if (qed_vld_out) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL stream: got %h expected nothing", qed_ifu_instruction);
            end else begin
               check("stream", qed_ifu_instruction, exp_q.pop_front());
            end
         end
      end
      prev_instr = qed_ifu_instruction;
      prev_vld   = qed_vld_out;
   end

   initial begin
      reset        = 1'b1;
      instruction  = 32'h0;
      instr_valid  = 1'b0;
      qed_exec_dup = 1'b0;
      stall        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_instr", qed_ifu_instruction, NOP);
      check("rst_vld", 32'(qed_vld_out), 32'd0);
      check("rst_ready", 32'(qed_ready), 32'd1);
      check("rst_count", 32'(queue_count), 32'd0);
      check("rst_illegal", 32'(illegal_seen), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Dup request with empty queue is ignored.
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("empty_dup_state", 32'(state_dbg), 32'd0);

      // add x3,x1,x2 -> add x19,x17,x18
      send_orig(32'h0020_81B3);
      check("add_count", 32'(queue_count), 32'd1);
      check("add_ready", 32'(qed_ready), 32'd0);
      exp_q.push_back(32'h0128_89B3);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("add_gap_instr", qed_ifu_instruction, NOP);
      check("add_gap_ready", 32'(qed_ready), 32'd0);
      check("add_dup_in_ready", 32'(in_ready), 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check("add_dup_ready", 32'(qed_ready), 32'd1);
      check("add_dup_state", 32'(state_dbg), 32'd0);

      // addi x0,x0,5 unchanged; lw x5,4(x0) -> lw x21,4(x0)
      send_orig(32'h0050_0013);
      send_orig(32'h0040_2283);
      exp_q.push_back(32'h0050_0013);
      exp_q.push_back(32'h0040_2A83);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check("x0_count", 32'(queue_count), 32'd0);

      // Illegal originals: beq, and add x20,x1,x2
      step(1'b1, 32'h0020_8463, 1'b0, 1'b0);
      check("beq_vld", 32'(qed_vld_out), 32'd0);
      check("beq_instr", qed_ifu_instruction, NOP);
      check("beq_illegal", 32'(illegal_seen), 32'd1);
      check("beq_count", 32'(queue_count), 32'd0);
      step(1'b1, 32'h0020_8A33, 1'b0, 1'b0);
      check("x20_vld", 32'(qed_vld_out), 32'd0);
      check("x20_count", 32'(queue_count), 32'd0);

      fill_and_drain(1'b0);
      fill_and_drain(1'b1);

      // Same-cycle push and dup with two queued: add, sub, then sw.
      send_orig(32'h0020_81B3);
      send_orig(32'h4062_8233);
      exp_q.push_back(32'h0071_2423);
      step(1'b1, 32'h0071_2423, 1'b1, 1'b0);
      check("same_cycle_count", 32'(queue_count), 32'd3);
      check("same_cycle_state", 32'(state_dbg), 32'd1);
      exp_q.push_back(32'h0128_89B3);
      exp_q.push_back(32'h416A_8A33);
      exp_q.push_back(32'h0179_2423);
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
      check("same_cycle_drained", 32'(queue_count), 32'd0);

      // Reset after 2 of 5 duplicates.
      for (int i = 0; i < 5; i++) send_orig(32'h0000_0093 | (32'(i) << 20));
      for (int i = 0; i < 5; i++) exp_q.push_back(32'h0000_0893 | (32'(i) << 20));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check("pre_rst_count", 32'(queue_count), 32'd3);
      reset = 1'b1;
      #2;
      check("mid_rst_count", 32'(queue_count), 32'd0);
      check("mid_rst_vld", 32'(qed_vld_out), 32'd0);
      check("mid_rst_instr", qed_ifu_instruction, NOP);
      check("mid_rst_state", 32'(state_dbg), 32'd0);
      check("mid_rst_illegal", 32'(illegal_seen), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_orig(32'h0020_81B3);
      check("post_rst_count", 32'(queue_count), 32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
